mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Accepts the ALU result, store data and decoded fields, and performs loads and stores against the data-cache port through a valid/ready request and valid response handshake.
- Aligns and sign/zero-extends load data, builds store byte strobes, and hands a single registered result to writeback with backpressure.

Parameters:
XLEN, 64, datapath width; only 64 is supported.
REG_IDX_W, 5, destination register index width.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ex_valid  input  1  execute result valid (driven from execute_done)
ex_ready  output  1  stage can accept an execute result this cycle
ex_alu_result  input  XLEN  ALU result; effective address for load/store
ex_store_data  input  XLEN  rs2 contents for stores
ex_opcode  input  7  instruction opcode
ex_funct3  input  3  size/sign selector
ex_dest_reg  input  REG_IDX_W  destination register
ex_pc  input  XLEN  instruction PC
dmem_req_valid  output  1  cache request valid
dmem_req_ready  input  1  cache accepts request
dmem_req_we  output  1  1 = store
dmem_req_addr  output  XLEN  doubleword-aligned address ({addr[63:3],3'b0})
dmem_req_wdata  output  XLEN  store data replicated into byte lanes
dmem_req_wstrb  output  8  store byte enables
dmem_resp_valid  input  1  load data valid
dmem_resp_rdata  input  XLEN  aligned doubleword read
wb_valid  output  1  result valid to writeback
wb_ready  input  1  writeback consumes result
wb_data  output  XLEN  writeback value
wb_dest_reg  output  REG_IDX_W  destination register
wb_reg_write  output  1  register file write enable
wb_pc  output  XLEN  instruction PC
wb_misaligned  output  1  misaligned-access exception flag

Behaviour:
- States: IDLE, REQ, RESP. Output register: wb_* fields with wb_valid.
- Reset: state = IDLE; wb_valid, wb_reg_write, wb_misaligned, dmem_req_valid = 0; wb_data, wb_pc, dmem_req_addr, wdata, wstrb = 0; wb_dest_reg = 0.
- Accept rule: ex_ready = (state == IDLE) && (!wb_valid || wb_ready). An accept occurs when ex_valid && ex_ready.
- Writeback drain: wb_valid clears on wb_valid && wb_ready unless a new result is loaded in the same cycle.
- Non-memory op accepted at cycle N: wb_valid = 1 at N+1. wb_data is:
  - ex_pc + 4 for JAL (1101111) and JALR (1100111);
  - otherwise ex_alu_result.
- wb_reg_write = 0 for branch (1100011), otherwise 1. wb_reg_write is forced to 0 when ex_dest_reg == 0.
- Alignment check on load/store, using addr = ex_alu_result:
  - size byte: always aligned;
  - half: addr[0] == 0;
  - word: addr[1:0] == 0;
  - double: addr[2:0] == 0.
- Misaligned load/store: no cache request is issued. Result at N+1 with wb_misaligned = 1, wb_reg_write = 0, wb_data = addr.
- Aligned load (0000011) or store (0100011): go to REQ at N+1 with dmem_req_valid = 1 and request fields registered.
  - Request fields hold stable until dmem_req_valid && dmem_req_ready.
- Store request handshake: return to IDLE and load a wb result with wb_reg_write = 0, wb_data = 0. The store completes on request acceptance; no response is expected.
- Load request handshake: go to RESP and deassert dmem_req_valid.
  - On dmem_resp_valid: shift rdata right by 8*addr[2:0], extend per funct3, and load wb result. Next state IDLE.
  - Extension per funct3: 000 LB sign; 001 LH sign; 010 LW sign; 011 LD; 100 LBU zero; 101 LHU zero; 110 LWU zero.
- Store encoding:
  - Strobe base by funct3: 000 → 0x01, 001 → 0x03, 010 → 0x0F, 011 → 0xFF; shifted left by addr[2:0].
  - wdata = store data replicated across lanes (byte ×8, half ×4, word ×2, double ×1).
- Unknown funct3 on load/store: treated as misaligned (exception path).
- dmem_resp_valid outside RESP is ignored. Responses arrive at least 1 cycle after request acceptance.
- Only one memory operation is outstanding; ex_ready = 0 in REQ and RESP.
- Reset mid-operation (REQ or RESP): state returns to IDLE and dmem_req_valid drops the next cycle. A late response is ignored and wb_valid = 0.
- Minimum latency: non-memory op 1 cycle; load 3 cycles (accept, req handshake, response).

Test Plan:
- ALU op rd=5, result 0x1234, wb_ready = 1 → next cycle wb_valid = 1, wb_data = 0x1234, wb_reg_write = 1; back-to-back accepts every cycle.
- LB at addr 0x1003, rdata 0x0000_0000_8000_0000 → wb_data = 0xFFFF_FFFF_FFFF_FF80. LBU at the same address → wb_data = 0x80.
- SH at addr 0x2006, data 0xBEEF, dmem_req_ready held low 3 cycles → request fields stable; wstrb = 0xC0, wdata = 0xBEEF replicated ×4; ex_ready = 0 until handshake.
- LW at addr 0x3002 → no dmem_req_valid; wb_misaligned = 1, wb_reg_write = 0, wb_data = 0x3002.
- Result held with wb_ready = 0 for 4 cycles → ex_ready = 0 and wb_* stable. wb_ready = 1 with a new ex_valid in the same cycle → drain and reload in one cycle.
- Reset asserted in RESP, then dmem_resp_valid pulses → state IDLE, wb_valid stays 0, the next op proceeds normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores to the data cache, aligns and
// extends load data, and presents one registered result to writeback.
module mem_access_stage #(
    parameter int XLEN      = 64,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [XLEN-1:0]      ex_alu_result,
    input  logic [XLEN-1:0]      ex_store_data,
    input  logic [6:0]           ex_opcode,
    input  logic [2:0]           ex_funct3,
    input  logic [REG_IDX_W-1:0] ex_dest_reg,
    input  logic [XLEN-1:0]      ex_pc,
    output logic                 dmem_req_valid,
    input  logic                 dmem_req_ready,
    output logic                 dmem_req_we,
    output logic [XLEN-1:0]      dmem_req_addr,
    output logic [XLEN-1:0]      dmem_req_wdata,
    output logic [7:0]           dmem_req_wstrb,
    input  logic                 dmem_resp_valid,
    input  logic [XLEN-1:0]      dmem_resp_rdata,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [XLEN-1:0]      wb_data,
    output logic [REG_IDX_W-1:0] wb_dest_reg,
    output logic                 wb_reg_write,
    output logic [XLEN-1:0]      wb_pc,
    output logic                 wb_misaligned
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unsupported size encodings are routed to the exception path as misaligned.
    function automatic logic is_misaligned(input logic is_store, input logic [2:0] f3,
                                           input logic [2:0] a);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a[1:0] != 2'b00);
            3'b011:  bad = (a != 3'b000);
            3'b100:  bad = is_store;
            3'b101:  bad = is_store | a[0];
            3'b110:  bad = is_store | (a[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [7:0] store_strb(input logic [2:0] f3, input logic [2:0] off);
        logic [7:0] base;
        case (f3[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (f3[1:0])
            2'b00:   w = {8{d[7:0]}};
            2'b01:   w = {4{d[15:0]}};
            2'b10:   w = {2{d[31:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [2:0] off,
                                                    input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] s;
        logic [XLEN-1:0] r;
        s = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{56{s[7]}}, s[7:0]};
            3'b001:  r = {{48{s[15]}}, s[15:0]};
            3'b010:  r = {{32{s[31]}}, s[31:0]};
            3'b100:  r = {56'd0, s[7:0]};
            3'b101:  r = {48'd0, s[15:0]};
            3'b110:  r = {32'd0, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    state_t                 r_state;
    logic                   r_wb_valid;
    logic [XLEN-1:0]        r_wb_data;
    logic [REG_IDX_W-1:0]   r_wb_dest;
    logic                   r_wb_reg_write;
    logic [XLEN-1:0]        r_wb_pc;
    logic                   r_wb_mis;
    logic                   r_req_valid;
    logic                   r_req_we;
    logic [XLEN-1:0]        r_req_addr;
    logic [XLEN-1:0]        r_req_wdata;
    logic [7:0]             r_req_wstrb;
    logic [2:0]             r_op_f3;
    logic [2:0]             r_op_off;
    logic [REG_IDX_W-1:0]   r_op_dest;
    logic [XLEN-1:0]        r_op_pc;

    state_t                 w_state_next;
    logic                   w_wb_valid_next;
    logic [XLEN-1:0]        w_wb_data_next;
    logic [REG_IDX_W-1:0]   w_wb_dest_next;
    logic                   w_wb_reg_write_next;
    logic [XLEN-1:0]        w_wb_pc_next;
    logic                   w_wb_mis_next;
    logic                   w_req_valid_next;
    logic                   w_req_we_next;
    logic [XLEN-1:0]        w_req_addr_next;
    logic [XLEN-1:0]        w_req_wdata_next;
    logic [7:0]             w_req_wstrb_next;
    logic [2:0]             w_op_f3_next;
    logic [2:0]             w_op_off_next;
    logic [REG_IDX_W-1:0]   w_op_dest_next;
    logic [XLEN-1:0]        w_op_pc_next;

    logic                   w_accept;
    logic                   w_ex_is_mem;
    logic                   w_ex_is_store;
    logic                   w_ex_mis;

    assign ex_ready      = (r_state == IDLE) && (!r_wb_valid || wb_ready);
    assign w_accept      = ex_valid && ex_ready;
    assign w_ex_is_store = (ex_opcode == OP_STORE);
    assign w_ex_is_mem   = (ex_opcode == OP_LOAD) || w_ex_is_store;
    assign w_ex_mis      = is_misaligned(w_ex_is_store, ex_funct3, ex_alu_result[2:0]);

    // Next-state and next-register computation for the stage FSM and output registers.
    always_comb begin
        w_state_next        = r_state;
        w_wb_valid_next     = r_wb_valid && !wb_ready;
        w_wb_data_next      = r_wb_data;
        w_wb_dest_next      = r_wb_dest;
        w_wb_reg_write_next = r_wb_reg_write;
        w_wb_pc_next        = r_wb_pc;
        w_wb_mis_next       = r_wb_mis;
        w_req_valid_next    = r_req_valid;
        w_req_we_next       = r_req_we;
        w_req_addr_next     = r_req_addr;
        w_req_wdata_next    = r_req_wdata;
        w_req_wstrb_next    = r_req_wstrb;
        w_op_f3_next        = r_op_f3;
        w_op_off_next       = r_op_off;
        w_op_dest_next      = r_op_dest;
        w_op_pc_next        = r_op_pc;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_ex_is_mem && !w_ex_mis) begin
                        w_state_next     = REQ;
                        w_req_valid_next = 1'b1;
                        w_req_we_next    = w_ex_is_store;
                        w_req_addr_next  = {ex_alu_result[XLEN-1:3], 3'b000};
                        w_req_wdata_next = store_wdata(ex_funct3, ex_store_data);
                        w_req_wstrb_next = store_strb(ex_funct3, ex_alu_result[2:0]);
                        w_op_f3_next     = ex_funct3;
                        w_op_off_next    = ex_alu_result[2:0];
                        w_op_dest_next   = ex_dest_reg;
                        w_op_pc_next     = ex_pc;
                    end else if (w_ex_is_mem) begin
                        w_wb_valid_next     = 1'b1;
                        w_wb_data_next      = ex_alu_result;
                        w_wb_dest_next      = ex_dest_reg;
                        w_wb_reg_write_next = 1'b0;
                        w_wb_pc_next        = ex_pc;
                        w_wb_mis_next       = 1'b1;
                    end else begin
                        w_wb_valid_next     = 1'b1;
                        w_wb_data_next      = ((ex_opcode == OP_JAL) || (ex_opcode == OP_JALR))
                                              ? ex_pc + 64'd4 : ex_alu_result;
                        w_wb_dest_next      = ex_dest_reg;
                        w_wb_reg_write_next = (ex_opcode != OP_BRANCH) && (ex_dest_reg != '0);
                        w_wb_pc_next        = ex_pc;
                        w_wb_mis_next       = 1'b0;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            REQ: begin
                if (r_req_valid && dmem_req_ready) begin
                    w_req_valid_next = 1'b0;
                    if (r_req_we) begin
                        // Stores retire on request acceptance; the cache sends no response.
                        w_state_next        = IDLE;
                        w_wb_valid_next     = 1'b1;
                        w_wb_data_next      = '0;
                        w_wb_dest_next      = r_op_dest;
                        w_wb_reg_write_next = 1'b0;
                        w_wb_pc_next        = r_op_pc;
                        w_wb_mis_next       = 1'b0;
                    end else begin
                        w_state_next = RESP;
                    end
                end else begin
                    w_state_next = REQ;
                end
            end
            RESP: begin
                if (dmem_resp_valid) begin
                    w_state_next        = IDLE;
                    w_wb_valid_next     = 1'b1;
                    w_wb_data_next      = load_extend(r_op_f3, r_op_off, dmem_resp_rdata);
                    w_wb_dest_next      = r_op_dest;
                    w_wb_reg_write_next = (r_op_dest != '0);
                    w_wb_pc_next        = r_op_pc;
                    w_wb_mis_next       = 1'b0;
                end else begin
                    w_state_next = RESP;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_req_valid_next = 1'b0;
            end
        endcase
    end

    // State, request and writeback registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_wb_valid     <= 1'b0;
            r_wb_data      <= '0;
            r_wb_dest      <= '0;
            r_wb_reg_write <= 1'b0;
            r_wb_pc        <= '0;
            r_wb_mis       <= 1'b0;
            r_req_valid    <= 1'b0;
            r_req_we       <= 1'b0;
            r_req_addr     <= '0;
            r_req_wdata    <= '0;
            r_req_wstrb    <= 8'h00;
            r_op_f3        <= 3'b000;
            r_op_off       <= 3'b000;
            r_op_dest      <= '0;
            r_op_pc        <= '0;
        end else begin
            r_state        <= w_state_next;
            r_wb_valid     <= w_wb_valid_next;
            r_wb_data      <= w_wb_data_next;
            r_wb_dest      <= w_wb_dest_next;
            r_wb_reg_write <= w_wb_reg_write_next;
            r_wb_pc        <= w_wb_pc_next;
            r_wb_mis       <= w_wb_mis_next;
            r_req_valid    <= w_req_valid_next;
            r_req_we       <= w_req_we_next;
            r_req_addr     <= w_req_addr_next;
            r_req_wdata    <= w_req_wdata_next;
            r_req_wstrb    <= w_req_wstrb_next;
            r_op_f3        <= w_op_f3_next;
            r_op_off       <= w_op_off_next;
            r_op_dest      <= w_op_dest_next;
            r_op_pc        <= w_op_pc_next;
        end
    end

    assign dmem_req_valid = r_req_valid;
    assign dmem_req_we    = r_req_we;
    assign dmem_req_addr  = r_req_addr;
    assign dmem_req_wdata = r_req_wdata;
    assign dmem_req_wstrb = r_req_wstrb;
    assign wb_valid       = r_wb_valid;
    assign wb_data        = r_wb_data;
    assign wb_dest_reg    = r_wb_dest;
    assign wb_reg_write   = r_wb_reg_write;
    assign wb_pc          = r_wb_pc;
    assign wb_misaligned  = r_wb_mis;

endmodule
